// File: rtl/io_sel_ctrl.sv
// rtl/io_sel_ctrl.sv - Wishbone-programmed shared-pin select with float/switch/settle sequencing.
// Optional build macro IO_SEL_LOCK_EN adds a write-once LOCK register.
module io_sel_ctrl #(
  parameter int                           NO_OF_SHARED_PINS = 13,
  parameter logic [NO_OF_SHARED_PINS-1:0] SEL_RESET         = '0,
  parameter logic [7:0]                   GUARD_RESET       = 8'd8,
  parameter logic [7:0]                   SETTLE_RESET      = 8'd4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [3:0]                   wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  input  logic [3:0]                   wb_sel_i,
  output logic [31:0]                  wb_dat_o,
  output logic                         wb_ack_o,
  output logic [NO_OF_SHARED_PINS-1:0] io_sel,
  output logic [NO_OF_SHARED_PINS-1:0] en_force,
  output logic                         busy
);
  localparam int N = NO_OF_SHARED_PINS;

  typedef enum logic [1:0] {IDLE, FLOAT, SWITCH, SETTLE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] io_sel_q, new_q, chg_q;
  logic [7:0]   g_q, s_q, s_lat_q, cnt_q;
  logic         ack_q, wr_err_q, lock_eff;
  logic [31:0]  dat_q, rd_data;
  logic [N-1:0] lane_mask, sel_wdata, chg;
  logic         wb_req, wr, sel_wr, guard_wr, stat_wr, lock_wr;
  logic         is_idle, sel_start, sel_err, guard_err, apply;
  logic         unused_bits;

  assign wb_req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr       = wb_req & wb_we_i;
  assign sel_wr   = wr & (wb_adr_i[3:2] == 2'd0);
  assign guard_wr = wr & (wb_adr_i[3:2] == 2'd1);
  assign stat_wr  = wr & (wb_adr_i[3:2] == 2'd2);
  assign lock_wr  = wr & (wb_adr_i[3:2] == 2'd3);
  assign is_idle  = (state_q == IDLE);

  // Unselected byte lanes keep the currently applied select bits.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < N; i++) lane_mask[i] = (i < 8) ? wb_sel_i[0] : wb_sel_i[1];
  end
  assign sel_wdata = (wb_dat_i[N-1:0] & lane_mask) | (io_sel_q & ~lane_mask);
  assign chg       = sel_wdata ^ io_sel_q;

  assign sel_start = sel_wr & is_idle & ~lock_eff & (|chg);
  assign sel_err   = sel_wr & (~is_idle | lock_eff);
  assign guard_err = guard_wr & lock_eff;

`ifdef IO_SEL_LOCK_EN
  logic lock_pend_q, locked_q;

  // A lock requested mid-sequence only bites once the sequence returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_pend_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      if (lock_wr & wb_sel_i[0] & wb_dat_i[0]) lock_pend_q <= 1'b1;
      if (lock_pend_q & is_idle)               locked_q    <= 1'b1;
    end
  end
  assign lock_eff = locked_q | (lock_pend_q & is_idle);
  assign unused_bits = ^{wb_dat_i[31:16], wb_sel_i[3:2], wb_adr_i[1:0]};
`else
  assign lock_eff = 1'b0;
  assign unused_bits = ^{wb_dat_i[31:16], wb_sel_i[3:2], wb_adr_i[1:0], lock_wr};
`endif

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    unique case (state_q)
      IDLE:   if (sel_start) state_d = FLOAT;
      FLOAT:  if (cnt_q == 8'd0) state_d = SWITCH;
      SWITCH: begin
        apply   = 1'b1;
        state_d = (s_lat_q == 8'd0) ? IDLE : SETTLE;
      end
      SETTLE: if (cnt_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // One counter serves both FLOAT (max(G,1) cycles) and SETTLE (S cycles).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      new_q    <= '0;
      chg_q    <= '0;
      s_lat_q  <= '0;
      io_sel_q <= SEL_RESET;
    end else begin
      if (sel_start) begin
        cnt_q   <= (g_q == 8'd0) ? 8'd0 : g_q - 8'd1;
        new_q   <= sel_wdata;
        chg_q   <= chg;
        s_lat_q <= s_q;
      end else if (state_q == SWITCH) begin
        cnt_q <= s_lat_q - 8'd1;
      end else if (cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (apply) io_sel_q <= new_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q      <= GUARD_RESET;
      s_q      <= SETTLE_RESET;
      wr_err_q <= 1'b0;
    end else begin
      if (guard_wr & ~lock_eff) begin
        if (wb_sel_i[0]) g_q <= wb_dat_i[7:0];
        if (wb_sel_i[1]) s_q <= wb_dat_i[15:8];
      end
      wr_err_q <= (wr_err_q & ~(stat_wr & wb_sel_i[0] & wb_dat_i[2])) | sel_err | guard_err;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (wb_adr_i[3:2])
      2'd0:    rd_data[N-1:0] = io_sel_q;
      2'd1:    rd_data[15:0]  = {s_q, g_q};
      2'd2:    rd_data[2:0]   = {wr_err_q, lock_eff, ~is_idle};
      default: rd_data        = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= wb_req;
      dat_q <= (wb_req & ~wb_we_i) ? rd_data : 32'd0;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign io_sel   = io_sel_q;
  assign busy     = ~is_idle;
  assign en_force = is_idle ? '0 : chg_q;
endmodule
